alu_commit_arbiter: RTL and testbench
=====================================

Name: alu_commit_arbiter

Overview:
- Shares the single register-file writeback port between N ALU commit interfaces (alu2 instances and siblings).
- Each ALU raises req/valid with res/o_rd/o_error. The arbiter picks one per cycle by round-robin, latches it into a registered writeback stage and pulses that ALU's clear input to release it.
- Sits between the execution units and the commiter/register file.

Parameters:
- N_UNITS, 4, number of ALU commit interfaces (2..8).
- XLEN, core_config_pkg::XLEN (32), data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register index width.
- SRC_W, $clog2(N_UNITS), width of the source-unit index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush: drop held result, no grant this cycle.
- unit_req  in  N_UNITS  per-unit commit request (ALU req).
- unit_valid  in  N_UNITS  per-unit result valid (ALU valid).
- unit_res  in  N_UNITS*XLEN  per-unit result; unit i at [i*XLEN +: XLEN].
- unit_rd  in  N_UNITS*REG_ADDR_W  per-unit destination; unit i at [i*REG_ADDR_W +: REG_ADDR_W].
- unit_error  in  N_UNITS  per-unit error flag (ALU o_error).
- unit_clear  out  N_UNITS  one-hot release to the granted ALU (drives ALU clear).
- wb_ready  in  1  writeback consumer accepts the held entry this cycle.
- wb_valid  out  1  writeback entry held.
- wb_we  out  1  register write enable = wb_valid & !wb_error & (wb_rd != 0).
- wb_rd  out  REG_ADDR_W  destination register.
- wb_data  out  XLEN  result data.
- wb_error  out  1  entry carries an ALU error (exception path, no RF write).
- wb_src  out  SRC_W  index of the unit that produced the entry.

Behaviour:
- Reset:
  - all outputs 0: wb_valid, wb_we, wb_rd, wb_data, wb_error, wb_src, unit_clear.
  - round-robin pointer = 0, so unit 0 has highest priority.
- Eligibility: unit i is eligible iff unit_req[i] & unit_valid[i]. req without valid is ignored.
- Capture slot: open iff !wb_valid | wb_ready, and !flush, and !rst.
- Grant (combinational):
  - when the slot is open and at least one unit is eligible, grant the first eligible unit scanning ptr, ptr+1, …, N_UNITS-1, 0, …, ptr-1.
  - unit_clear = one-hot of the granted unit, in the same cycle; otherwise all 0.
  - the ALU is expected to drop req by the next edge.
- Capture (registered, next edge):
  - wb_valid=1; wb_data, wb_rd, wb_error, wb_src loaded from the granted unit.
  - ptr = (grant+1) mod N_UNITS, wrapping from N_UNITS-1 to 0.
- Pop:
  - wb_valid & wb_ready with no new grant → wb_valid=0 next edge.
  - pop and grant in the same cycle → new entry replaces the old one. Back-to-back throughput is 1 entry/cycle.
- Hold: wb_valid & !wb_ready → all wb_* stable, no grant, unit_clear=0, ptr unchanged.
- Latency: eligible at cycle t with slot open → wb_valid visible at t+1; clear pulses during cycle t.
- wb_we is derived combinationally from the registered fields.
  - rd=x0 entries are still presented (wb_valid=1) so the commiter retires them, but wb_we=0.
- flush:
  - next edge wb_valid=0; unit_clear=0 during flush; ptr unchanged.
  - ALUs are cleared by their own flush path, not by this block.
- Reset mid-operation: a held entry is discarded and unit_clear stays 0 in the reset cycle.
- No internal storage beyond one entry plus ptr. No grant to a unit whose clear is already being pulsed: by construction one grant per cycle.

Test Plan:
- Single requester: reset, unit 2 req=valid=1, res=0x0000_00AA, rd=5, wb_ready=1 → unit_clear=4'b0100 that cycle; next cycle wb_valid=1, wb_data=0xAA, wb_rd=5, wb_src=2, wb_we=1.
- Round-robin fairness: all 4 units eligible continuously, wb_ready=1 → grant order 0,1,2,3,0 on consecutive cycles; exactly one unit_clear bit per cycle.
- Backpressure: entry from unit 1 held with wb_ready=0 for 3 cycles while unit 3 is eligible → wb_* unchanged, unit_clear=0; wb_ready=1 → unit 3 captured the same cycle, wb_src=3 next cycle.
- x0 and error: unit 0 rd=0 → wb_valid=1, wb_we=0. Unit 1 error=1, rd=7 → wb_error=1, wb_we=0.
- req without valid: unit 2 req=1, valid=0 → no grant, unit_clear=0, wb_valid stays 0.
- Flush/reset mid-op: entry held, flush=1 with unit 0 eligible → wb_valid=0 next cycle, no clear. Repeat with rst=1 → all outputs 0, ptr=0, so unit 0 wins the next tie against unit 3.

Source files
------------

// File: rtl/alu_commit_arbiter.sv
// Round-robin arbiter that shares the register-file writeback port among N ALU
// commit interfaces. It holds a single registered entry and releases the granted ALU.
package core_config_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
endpackage

module alu_commit_arbiter #(
  parameter int unsigned N_UNITS    = 4,
  parameter int unsigned XLEN       = core_config_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W,
  parameter int unsigned SRC_W      = $clog2(N_UNITS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [N_UNITS-1:0]             unit_req,
  input  logic [N_UNITS-1:0]             unit_valid,
  input  logic [N_UNITS*XLEN-1:0]        unit_res,
  input  logic [N_UNITS*REG_ADDR_W-1:0]  unit_rd,
  input  logic [N_UNITS-1:0]             unit_error,
  output logic [N_UNITS-1:0]             unit_clear,
  input  logic                           wb_ready,
  output logic                           wb_valid,
  output logic                           wb_we,
  output logic [REG_ADDR_W-1:0]          wb_rd,
  output logic [XLEN-1:0]                wb_data,
  output logic                           wb_error,
  output logic [SRC_W-1:0]               wb_src
);

  logic [N_UNITS-1:0]    eligible;
  logic                  slot_open;
  logic                  grant_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant;

  logic [XLEN-1:0]       res_arr [N_UNITS];
  logic [REG_ADDR_W-1:0] rd_arr  [N_UNITS];

  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_data_q,  wb_data_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,    wb_rd_d;
  logic                  wb_error_q, wb_error_d;
  logic [SRC_W-1:0]      wb_src_q,   wb_src_d;
  logic [SRC_W-1:0]      ptr_q,      ptr_d;

  always_comb begin
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      res_arr[i] = unit_res[i*XLEN +: XLEN];
      rd_arr[i]  = unit_rd[i*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  assign eligible  = unit_req & unit_valid;
  assign slot_open = (!wb_valid_q || wb_ready) && !flush && !rst;

  // Scan starting at ptr_q and wrapping; the first eligible unit wins.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned off = 0; off < N_UNITS; off++) begin
      cand = (32'(ptr_q) + off) % N_UNITS;
      if (!grant_found && eligible[SRC_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  assign grant = slot_open && grant_found;

  always_comb begin
    unit_clear = '0;
    if (grant) begin
      unit_clear[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_error_d = wb_error_q;
    wb_src_d   = wb_src_q;
    ptr_d      = ptr_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (grant) begin
      wb_valid_d = 1'b1;
      wb_data_d  = res_arr[grant_idx];
      wb_rd_d    = rd_arr[grant_idx];
      wb_error_d = unit_error[grant_idx];
      wb_src_d   = grant_idx;
      if (grant_idx == SRC_W'(N_UNITS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SRC_W'(1);
      end
    end else if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_error_q <= 1'b0;
      wb_src_q   <= '0;
      ptr_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_error_q <= wb_error_d;
      wb_src_q   <= wb_src_d;
      ptr_q      <= ptr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_error = wb_error_q;
  assign wb_src   = wb_src_q;
  // x0 and faulting entries still retire, they just never touch the register file.
  assign wb_we    = wb_valid_q && !wb_error_q && (wb_rd_q != '0);

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Directed bench for alu_commit_arbiter: stimulus pushes expected writeback entries,
// a negedge monitor pops and compares them whenever an entry is accepted.
module tb_alu_commit_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned XL = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              rst, flush, wb_ready;
  logic [N-1:0]      unit_req, unit_valid, unit_error, unit_clear;
  logic [N*XL-1:0]   unit_res;
  logic [N*RW-1:0]   unit_rd;
  logic              wb_valid, wb_we, wb_error;
  logic [RW-1:0]     wb_rd;
  logic [XL-1:0]     wb_data;
  logic [SW-1:0]     wb_src;

  typedef struct {
    logic [XL-1:0] data;
    logic [RW-1:0] rd;
    logic          err;
    logic [SW-1:0] src;
    logic          we;
  } entry_t;

  entry_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  alu_commit_arbiter #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .unit_req(unit_req), .unit_valid(unit_valid), .unit_res(unit_res),
    .unit_rd(unit_rd), .unit_error(unit_error), .unit_clear(unit_clear),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_error(wb_error), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic req, input logic vld,
                          input logic [XL-1:0] res, input logic [RW-1:0] rd, input logic err);
    unit_req[i]           = req;
    unit_valid[i]         = vld;
    unit_res[i*XL +: XL]  = res;
    unit_rd[i*RW +: RW]   = rd;
    unit_error[i]         = err;
  endtask

  task automatic drop(input int i);
    set_unit(i, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic expect_entry(input logic [XL-1:0] d, input logic [RW-1:0] rd,
                              input logic err, input logic [SW-1:0] src);
    entry_t e;
    e.data = d; e.rd = rd; e.err = err; e.src = src;
    e.we   = !err && (rd != 0);
    exp_q.push_back(e);
  endtask

  // Accepted entries are compared; flushed or reset entries are discarded unchecked.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (rst || flush) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (wb_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_entry", {63'd0, wb_valid}, 64'd0);
          end else begin
            entry_t e;
            e = exp_q.pop_front();
            chk("sb_data",  64'(wb_data),  64'(e.data));
            chk("sb_rd",    64'(wb_rd),    64'(e.rd));
            chk("sb_error", 64'(wb_error), 64'(e.err));
            chk("sb_src",   64'(wb_src),   64'(e.src));
            chk("sb_we",    64'(wb_we),    64'(e.we));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    unit_req = '0; unit_valid = '0; unit_error = '0; unit_res = '0; unit_rd = '0;
    step(); step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_we",    64'(wb_we),    64'd0);
    chk("rst_wb_data",  64'(wb_data),  64'd0);
    chk("rst_wb_rd",    64'(wb_rd),    64'd0);
    chk("rst_wb_error", 64'(wb_error), 64'd0);
    chk("rst_wb_src",   64'(wb_src),   64'd0);
    chk("rst_clear",    64'(unit_clear), 64'd0);

    // Single requester: unit 2
    rst = 1'b0; wb_ready = 1'b1;
    set_unit(2, 1'b1, 1'b1, 32'h0000_00AA, 5'd5, 1'b0);
    #1 chk("single_clear", 64'(unit_clear), 64'b0100);
    expect_entry(32'hAA, 5'd5, 1'b0, 2'd2);
    step(); drop(2);
    #1 chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_we", 64'(wb_we), 64'd1);
    step();
    chk("single_pop", 64'(wb_valid), 64'd0);

    // Round-robin from a freshly reset pointer
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_unit(i, 1'b1, 1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] one;
      one = '0;
      one[k % 4] = 1'b1;
      #1 chk($sformatf("rr_clear_%0d", k), 64'(unit_clear), 64'(one));
      expect_entry(32'h100 + 32'(k % 4), 5'((k % 4) + 1), 1'b0, 2'(k % 4));
      step();
    end
    for (int i = 0; i < 4; i++) drop(i);
    step();
    chk("rr_drain", 64'(wb_valid), 64'd0);

    // Backpressure: unit 1 held while unit 3 waits (pointer now 1)
    set_unit(1, 1'b1, 1'b1, 32'h11, 5'd9, 1'b0);
    #1 chk("bp_clear1", 64'(unit_clear), 64'b0010);
    expect_entry(32'h11, 5'd9, 1'b0, 2'd1);
    step(); drop(1);
    wb_ready = 1'b0;
    set_unit(3, 1'b1, 1'b1, 32'h33, 5'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp_hold_clear_%0d", c), 64'(unit_clear), 64'd0);
      chk($sformatf("bp_hold_src_%0d", c),  64'(wb_src),  64'd1);
      chk($sformatf("bp_hold_data_%0d", c), 64'(wb_data), 64'h11);
      step();
    end
    wb_ready = 1'b1;
    #1 chk("bp_release_clear", 64'(unit_clear), 64'b1000);
    expect_entry(32'h33, 5'd3, 1'b0, 2'd3);
    step(); drop(3);
    #1 chk("bp_src3", 64'(wb_src), 64'd3);
    step();

    // x0 destination, then an error entry back-to-back (pointer now 0)
    set_unit(0, 1'b1, 1'b1, 32'h55, 5'd0, 1'b0);
    #1 chk("x0_clear", 64'(unit_clear), 64'b0001);
    expect_entry(32'h55, 5'd0, 1'b0, 2'd0);
    step(); drop(0);
    set_unit(1, 1'b1, 1'b1, 32'h77, 5'd7, 1'b1);
    #1 chk("x0_valid", 64'(wb_valid), 64'd1);
    chk("x0_we", 64'(wb_we), 64'd0);
    chk("err_clear", 64'(unit_clear), 64'b0010);
    expect_entry(32'h77, 5'd7, 1'b1, 2'd1);
    step(); drop(1);
    #1 chk("err_flag", 64'(wb_error), 64'd1);
    chk("err_we", 64'(wb_we), 64'd0);
    step();

    // req without valid is ignored
    set_unit(2, 1'b1, 1'b0, 32'hDEAD, 5'd4, 1'b0);
    #1 chk("novld_clear", 64'(unit_clear), 64'd0);
    step();
    chk("novld_valid", 64'(wb_valid), 64'd0);
    drop(2);

    // Flush with a held entry and unit 0 eligible
    wb_ready = 1'b0;
    set_unit(0, 1'b1, 1'b1, 32'hF0, 5'd2, 1'b0);
    #1 chk("fl_grant", 64'(unit_clear), 64'b0001);
    expect_entry(32'hF0, 5'd2, 1'b0, 2'd0);
    step();
    flush = 1'b1;
    set_unit(0, 1'b1, 1'b1, 32'hF1, 5'd2, 1'b0);
    #1 chk("fl_clear", 64'(unit_clear), 64'd0);
    step(); flush = 1'b0; drop(0);
    chk("fl_valid", 64'(wb_valid), 64'd0);

    // Reset mid-operation: held entry from unit 1 moves the pointer to 2
    set_unit(1, 1'b1, 1'b1, 32'h1C, 5'd4, 1'b0);
    #1 chk("rm_grant", 64'(unit_clear), 64'b0010);
    expect_entry(32'h1C, 5'd4, 1'b0, 2'd1);
    step(); drop(1);
    rst = 1'b1;
    set_unit(0, 1'b1, 1'b1, 32'hA0, 5'd10, 1'b0);
    set_unit(3, 1'b1, 1'b1, 32'hA3, 5'd13, 1'b0);
    #1 chk("rm_clear", 64'(unit_clear), 64'd0);
    step(); rst = 1'b0;
    chk("rm_valid", 64'(wb_valid), 64'd0);
    chk("rm_data",  64'(wb_data),  64'd0);
    chk("rm_src",   64'(wb_src),   64'd0);
    wb_ready = 1'b1;
    #1 chk("rm_tie_clear", 64'(unit_clear), 64'b0001);
    expect_entry(32'hA0, 5'd10, 1'b0, 2'd0);
    step(); drop(0); drop(3);
    #1 chk("rm_tie_src", 64'(wb_src), 64'd0);
    step(); step();

    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
